// File: rtl/pe_seq_pkg.sv
// pe_seq_pkg: state encoding and default widths for the PE start sequencer.
package pe_seq_pkg;

    localparam int NUM_PE_DEF    = 8;
    localparam int CNT_WIDTH_DEF = 16;
    localparam int GAP_WIDTH_DEF = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        RUN       = 3'd2,
        RAMP_DOWN = 3'd3,
        DONE      = 3'd4
    } state_t;

endpackage

// File: rtl/pe_seq_walker.sv
// pe_seq_walker: idx/gcnt stepper producing one tile strobe every gap+1 enabled cycles.
module pe_seq_walker
    import pe_seq_pkg::*;
#(
    parameter int NUM_PE    = NUM_PE_DEF,
    parameter int GAP_WIDTH = GAP_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 en,
    input  logic [GAP_WIDTH-1:0] gap,
    output logic [NUM_PE-1:0]    step,
    output logic                 last
);

    localparam int IW = NUM_PE > 1 ? $clog2(NUM_PE) : 1;

    logic [IW-1:0]        idx;
    logic [GAP_WIDTH-1:0] gcnt;
    logic                 hit;

    assign hit  = en && gcnt == gap;
    assign step = hit ? NUM_PE'(1) << idx : '0;
    assign last = hit && idx == IW'(NUM_PE - 1);

    // gcnt counts gap cycles, idx advances one tile slot each time the gap elapses
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx  <= '0;
            gcnt <= '0;
        end else if (en) begin
            gcnt <= hit ? '0 : gcnt + GAP_WIDTH'(1);
            idx  <= hit ? idx + IW'(1) : idx;
        end
    end

endmodule

// File: rtl/pe_start_sequencer.sv
// pe_start_sequencer: wavefront ramp-up/run/ramp-down of per-tile ap_start; optional freeze via PE_SEQ_STALL_EN.
module pe_start_sequencer
    import pe_seq_pkg::*;
#(
    parameter int NUM_PE    = NUM_PE_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int GAP_WIDTH = GAP_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [NUM_PE-1:0]    cmd_mask,
    input  logic [CNT_WIDTH-1:0] cmd_cycles,
    input  logic [GAP_WIDTH-1:0] cmd_gap,
    input  logic                 abort,
    output logic [NUM_PE-1:0]    ap_start,
    output logic                 busy,
    output logic                 done
`ifdef PE_SEQ_STALL_EN
    ,
    input  logic                 stall
`endif
);

    state_t               state;
    logic [NUM_PE-1:0]    mask_q, ap_reg, step;
    logic [CNT_WIDTH-1:0] cyc_q, run_cnt;
    logic [GAP_WIDTH-1:0] gap_q;
    logic                 stall_i, last, go, ramp, run_end, abort_ok, clr;

`ifdef PE_SEQ_STALL_EN
    assign stall_i  = stall;
    assign ap_start = ap_reg & ~{NUM_PE{stall}};
`else
    assign stall_i  = 1'b0;
    assign ap_start = ap_reg;
`endif

    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign go        = cmd_valid && state == IDLE && |cmd_mask && |cmd_cycles;
    assign ramp      = state == RAMP_UP || state == RAMP_DOWN;
    assign run_end   = state == RUN && run_cnt == CNT_WIDTH'(1);
    assign abort_ok  = abort && (state == RAMP_UP || state == RUN);
    assign clr       = !stall_i && (go || run_end || abort_ok);

    pe_seq_walker #(.NUM_PE(NUM_PE), .GAP_WIDTH(GAP_WIDTH)) u_walker (
        .clk   (clk),
        .reset (reset),
        .clear (clr),
        .en    (ramp && !stall_i),
        .gap   (gap_q),
        .step  (step),
        .last  (last)
    );

    // sequence FSM: set enables on the way up, count the run, clear on the way down; everything holds while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ap_reg  <= '0;
            mask_q  <= '0;
            cyc_q   <= '0;
            gap_q   <= '0;
            run_cnt <= '0;
        end else if (!stall_i) begin
            case (state)
                IDLE: if (cmd_valid) begin
                    mask_q <= cmd_mask;
                    cyc_q  <= cmd_cycles;
                    gap_q  <= cmd_gap;
                    state  <= go ? RAMP_UP : DONE;
                end
                RAMP_UP: if (abort) begin
                    state <= RAMP_DOWN;
                end else begin
                    ap_reg <= ap_reg | (step & mask_q);
                    if (last) begin
                        state   <= RUN;
                        run_cnt <= cyc_q;
                    end
                end
                RUN: if (abort || run_end) state <= RAMP_DOWN;
                     else run_cnt <= run_cnt - CNT_WIDTH'(1);
                RAMP_DOWN: begin
                    ap_reg <= ap_reg & ~step;
                    if (last) state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_start_sequencer.sv
// tb_pe_start_sequencer: table-driven command vectors with hand-computed edge timings, plus reset/stall sequences.
module tb_pe_start_sequencer;

    typedef struct packed {
        logic [3:0]      mask;
        logic [15:0]     cycles;
        logic [3:0]      gap;
        logic [7:0]      abort_at;
        logic [7:0]      stall_at;
        logic [7:0]      stall_len;
        logic [3:0][7:0] rise;
        logic [3:0][7:0] fall;
        logic [7:0]      done_at;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, cmd_valid, abort, stall;
    logic [3:0]  cmd_mask, ap_start;
    logic [15:0] cmd_cycles;
    logic [3:0]  cmd_gap;
    logic        cmd_ready, busy, done;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[10];
    int          nv;

    always #5 clk = ~clk;

    pe_start_sequencer #(.NUM_PE(4), .CNT_WIDTH(16), .GAP_WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mask   (cmd_mask),
        .cmd_cycles (cmd_cycles),
        .cmd_gap    (cmd_gap),
        .abort      (abort),
        .ap_start   (ap_start),
        .busy       (busy),
        .done       (done)
`ifdef PE_SEQ_STALL_EN
        ,
        .stall      (stall)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Edges are numbered from the accept edge (0); rise/fall/done record the edge after which the change is seen.
    task automatic run_vec(input int k, input vec_t v);
        int rise[4];
        int fall[4];
        int dn = -1;
        for (int i = 0; i < 4; i++) begin
            rise[i] = 0;
            fall[i] = 0;
        end
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_mask   = v.mask;
        cmd_cycles = v.cycles;
        cmd_gap    = v.gap;
        chk($sformatf("v%0d ready_before", k), cmd_ready, 1);
        for (int n = 0; n <= 300 && dn < 0; n++) begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            if (stall) begin
                chk($sformatf("v%0d stall_ap@%0d", k, n), ap_start, 0);
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (ap_start[i] && rise[i] == 0) rise[i] = n;
                    if (!ap_start[i] && rise[i] != 0 && fall[i] == 0) fall[i] = n;
                end
            end
            if (done) begin
                dn = n;
                chk($sformatf("v%0d busy_at_done", k), busy, 1);
            end
            abort = (int'(v.abort_at) == n + 1);
            stall = v.stall_len != 0 && n + 1 >= int'(v.stall_at) && n + 1 < int'(v.stall_at) + int'(v.stall_len);
        end
        abort = 1'b0;
        stall = 1'b0;
        if (dn < 0) $display("FAIL v%0d timeout: got no done expected done", k);
        if (dn < 0) errors++;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("v%0d rise%0d", k, i), rise[i], int'(v.rise[i]));
            chk($sformatf("v%0d fall%0d", k, i), fall[i], int'(v.fall[i]));
        end
        chk($sformatf("v%0d done_edge", k), dn, int'(v.done_at));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d done_pulse_end", k), done, 0);
        chk($sformatf("v%0d ready_after", k), cmd_ready, 1);
        chk($sformatf("v%0d busy_after", k), busy, 0);
        chk($sformatf("v%0d ap_after", k), ap_start, 0);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0; stall = 1'b0;
        cmd_mask = '0; cmd_cycles = '0; cmd_gap = '0;
        // mask, cycles, gap, abort_at, stall_at, stall_len, rise{3..0}, fall{3..0}, done
        vecs[0] = '{4'b1111, 16'd5,  4'd1,  8'd0,  8'd0, 8'd0, {8'd8, 8'd6, 8'd4, 8'd2}, {8'd21, 8'd19, 8'd17, 8'd15}, 8'd21};
        vecs[1] = '{4'b0101, 16'd3,  4'd0,  8'd0,  8'd0, 8'd0, {8'd0, 8'd3, 8'd0, 8'd1}, {8'd0, 8'd10, 8'd0, 8'd8},    8'd11};
        vecs[2] = '{4'b0000, 16'd5,  4'd1,  8'd0,  8'd0, 8'd0, 32'd0, 32'd0, 8'd0};
        vecs[3] = '{4'b1111, 16'd0,  4'd3,  8'd0,  8'd0, 8'd0, 32'd0, 32'd0, 8'd0};
        vecs[4] = '{4'b1000, 16'd1,  4'd2,  8'd0,  8'd0, 8'd0, {8'd12, 8'd0, 8'd0, 8'd0}, {8'd25, 8'd0, 8'd0, 8'd0}, 8'd25};
        vecs[5] = '{4'b0001, 16'd2,  4'd15, 8'd0,  8'd0, 8'd0, {8'd0, 8'd0, 8'd0, 8'd16}, {8'd0, 8'd0, 8'd0, 8'd82}, 8'd130};
        vecs[6] = '{4'b1111, 16'd10, 4'd0,  8'd6,  8'd0, 8'd0, {8'd4, 8'd3, 8'd2, 8'd1}, {8'd10, 8'd9, 8'd8, 8'd7},   8'd10};
        vecs[7] = '{4'b1111, 16'd5,  4'd1,  8'd5,  8'd0, 8'd0, {8'd0, 8'd0, 8'd4, 8'd2}, {8'd0, 8'd0, 8'd9, 8'd7},    8'd13};
        vecs[8] = '{4'b1111, 16'd5,  4'd1,  8'd16, 8'd0, 8'd0, {8'd8, 8'd6, 8'd4, 8'd2}, {8'd21, 8'd19, 8'd17, 8'd15}, 8'd21};
        nv = 9;
`ifdef PE_SEQ_STALL_EN
        vecs[9] = '{4'b1111, 16'd5,  4'd1,  8'd0,  8'd4, 8'd4, {8'd12, 8'd10, 8'd8, 8'd2}, {8'd25, 8'd23, 8'd21, 8'd19}, 8'd25};
        nv = 10;
`endif
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset ap_start", ap_start, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset cmd_ready", cmd_ready, 1);
        for (int k = 0; k < nv; k++) run_vec(k, vecs[k]);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mask = 4'b1111; cmd_cycles = 16'd10; cmd_gap = 4'd0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("pre_reset ap_start", ap_start, 15);
        chk("pre_reset busy", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("post_reset ap_start", ap_start, 0);
        chk("post_reset busy", busy, 0);
        chk("post_reset cmd_ready", cmd_ready, 1);
        run_vec(20, vecs[1]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
